bist_response_analyzer: RTL and testbench

- Read-back end of the 256x4 SRAM BIST: the pattern/march generator writes and issues reads; this block receives those read strobes and checks them.
- For each read, it aligns the expected data with the SRAM output after the read latency and compares them.
- Counts mismatches, captures the first failing location and drives the session GoNoGo verdict.
- Sits between the generator's read port and the SRAM Data_output inside the full BIST.

---
 rtl/bist_response_analyzer.sv | 143 ++++++++++++++
 tb/tb_bist_response_analyzer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_response_analyzer.sv
// Read-back checker for the SRAM BIST: aligns expected data with SRAM output,
// counts mismatches, captures the first failure and drives GoNoGo. Optional MISR via BIST_MISR_EN.
module bist_response_analyzer #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 4,
  parameter int READ_LAT = 1,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              last,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              done,
  output logic              GoNoGo,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_act,
  output logic [15:0]       signature
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN, S_DONE} state_t;

  state_t state, state_nxt;

  logic [READ_LAT-1:0] pipe_valid;
  logic [READ_LAT-1:0] pipe_last;
  logic [ADDR_W-1:0]   pipe_addr [READ_LAT];
  logic [DATA_W-1:0]   pipe_exp  [READ_LAT];

  logic load, cmp_fire, cmp_last, mismatch, first_seen;

  // Reads are only accepted while collecting; a start in the same cycle always wins.
  assign load     = (state == S_ACTIVE) && rd_en && !start;
  assign cmp_fire = pipe_valid[READ_LAT-1] && !start &&
                    ((state == S_ACTIVE) || (state == S_DRAIN));
  assign cmp_last = cmp_fire && pipe_last[READ_LAT-1];
  assign mismatch = cmp_fire && (mem_dout != pipe_exp[READ_LAT-1]);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every signal assigned in a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start) state_nxt = S_ACTIVE;
      S_ACTIVE: if (start) state_nxt = S_ACTIVE;
                else if (load && last) state_nxt = S_DRAIN;
      S_DRAIN:  if (start) state_nxt = S_ACTIVE;
                else if (cmp_last) state_nxt = S_DONE;
      S_DONE:   state_nxt = start ? S_ACTIVE : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_ACTIVE) || (state == S_DRAIN);
    done = (state == S_DONE);
  end

  // Valid and last tags are control and must reset/flush; start discards in-flight reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid <= '0;
      pipe_last  <= '0;
    end else if (start) begin
      pipe_valid <= '0;
      pipe_last  <= '0;
    end else begin
      pipe_valid[0] <= load;
      pipe_last[0]  <= load && last;
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_last[i]  <= pipe_last[i-1];
      end
    end
  end

  // NOTE: the address/data payload is qualified by pipe_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    pipe_addr[0] <= rd_addr;
    pipe_exp[0]  <= exp_data;
    for (int i = 1; i < READ_LAT; i++) begin
      pipe_addr[i] <= pipe_addr[i-1];
      pipe_exp[i]  <= pipe_exp[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count  <= '0;
      fail_addr  <= '0;
      fail_exp   <= '0;
      fail_act   <= '0;
      first_seen <= 1'b0;
      GoNoGo     <= 1'b0;
    end else if (start) begin
      err_count  <= '0;
      fail_addr  <= '0;
      fail_exp   <= '0;
      fail_act   <= '0;
      first_seen <= 1'b0;
      GoNoGo     <= 1'b0;
    end else begin
      if (mismatch) begin
        if (err_count != {CNT_W{1'b1}}) err_count <= err_count + CNT_W'(1);
        if (!first_seen) begin
          first_seen <= 1'b1;
          fail_addr  <= pipe_addr[READ_LAT-1];
          fail_exp   <= pipe_exp[READ_LAT-1];
          fail_act   <= mem_dout;
        end
      end
      // The verdict must include the final compare, which may itself mismatch.
      if (cmp_last) GoNoGo <= (err_count == '0) && !mismatch;
    end
  end

`ifdef BIST_MISR_EN
  logic [15:0] misr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           misr <= 16'h0000;
    else if (start)    misr <= 16'hFFFF;
    else if (cmp_fire) misr <= {misr[14:0], 1'b0} ^ (misr[15] ? 16'h1021 : 16'h0000)
                               ^ 16'(mem_dout);
  end

  assign signature = misr;
`else
  assign signature = 16'h0000;
`endif

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Self-checking bench for bist_response_analyzer: session-level reference model
// compared every cycle, plus directed sessions with hand-computed results.
module tb_bist_response_analyzer;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_addr = '0;
  logic [3:0] exp_data = '0;
  logic       last = 1'b0;
  logic [3:0] mem_dout = '0;
  logic       busy, done, GoNoGo;
  logic [7:0] err_count, fail_addr;
  logic [3:0] fail_exp, fail_act;
  logic [15:0] signature;

  bist_response_analyzer #(.ADDR_W(8), .DATA_W(4), .READ_LAT(LAT), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
    .exp_data(exp_data), .last(last), .mem_dout(mem_dout), .busy(busy), .done(done),
    .GoNoGo(GoNoGo), .err_count(err_count), .fail_addr(fail_addr), .fail_exp(fail_exp),
    .fail_act(fail_act), .signature(signature)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: observable results plus a queue of outstanding reads.
  typedef struct {
    bit         busy, done, gonogo;
    int         err;
    logic [7:0] fa;
    logic [3:0] fe, fact;
    logic [15:0] sig;
  } obs_t;

  typedef struct {
    int         due;
    logic [7:0] addr;
    logic [3:0] exp, act;
    bit         lst;
  } rd_t;

  obs_t nxt, vis;
  rd_t  pend[$];
  bit   in_sess, last_issued, captured;
  int   cyc = 0;
  logic [3:0] cur_act = '0;
  logic [3:0] act_ring [8];
  bit   chk_en = 0;
  int   done_count = 0;

  task automatic model_reset();
    in_sess = 0; last_issued = 0; captured = 0;
    pend.delete();
    nxt = '{busy: 0, done: 0, gonogo: 0, err: 0, fa: 0, fe: 0, fact: 0, sig: 0};
  endtask

  task automatic model_eval();
    rd_t e;
    nxt.done = 0;
    if (rst) begin
      model_reset();
      return;
    end
    if (start) begin
      in_sess = 1; last_issued = 0; captured = 0;
      pend.delete();
      nxt.err = 0; nxt.fa = 0; nxt.fe = 0; nxt.fact = 0; nxt.gonogo = 0;
`ifdef BIST_MISR_EN
      nxt.sig = 16'hFFFF;
`endif
      nxt.busy = 1;
      return;
    end
    if (in_sess && pend.size() > 0 && pend[0].due == cyc) begin
      e = pend.pop_front();
      if (e.act != e.exp) begin
        if (nxt.err < 255) nxt.err = nxt.err + 1;
        if (!captured) begin
          captured = 1; nxt.fa = e.addr; nxt.fe = e.exp; nxt.fact = e.act;
        end
      end
`ifdef BIST_MISR_EN
      nxt.sig = {nxt.sig[14:0], 1'b0} ^ (nxt.sig[15] ? 16'h1021 : 16'h0) ^ {12'h0, e.act};
`endif
      if (e.lst) begin
        in_sess = 0;
        nxt.gonogo = (nxt.err == 0);
        nxt.done = 1;
      end
    end
    if (in_sess && !last_issued && rd_en) begin
      pend.push_back('{due: cyc + LAT, addr: rd_addr, exp: exp_data, act: cur_act, lst: last});
      if (last) last_issued = 1;
    end
    nxt.busy = in_sess;
  endtask

  // Inputs for the current cycle are set; advance one clock and play the SRAM.
  task automatic step();
    model_eval();
    if (rd_en) act_ring[(cyc + LAT) % 8] = cur_act;
    @(posedge clk);
    vis = nxt;
    #1;
    cyc++;
    mem_dout = act_ring[cyc % 8];
    act_ring[cyc % 8] = 4'h0;
    start = 0; rd_en = 0; last = 0;
  endtask

  task automatic issue(input logic [7:0] a, input logic [3:0] e, input logic [3:0] act, input bit lst);
    rd_en = 1; rd_addr = a; exp_data = e; cur_act = act; last = lst;
    step();
  endtask

  task automatic begin_session();
    start = 1;
    step();
  endtask

  task automatic wait_done();
    int k = 0;
    while (done !== 1'b1 && k < 200) begin
      step();
      k++;
    end
    check("done_within_budget", 32'(done), 32'd1);
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) done_count++;
    if (chk_en) begin
      check("busy", 32'(busy), 32'(vis.busy));
      check("done", 32'(done), 32'(vis.done));
      check("GoNoGo", 32'(GoNoGo), 32'(vis.gonogo));
      check("err_count", 32'(err_count), 32'(vis.err));
      check("fail_addr", 32'(fail_addr), 32'(vis.fa));
      check("fail_exp", 32'(fail_exp), 32'(vis.fe));
      check("fail_act", 32'(fail_act), 32'(vis.fact));
      check("signature", 32'(signature), 32'(vis.sig));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_last, d0;
    for (int i = 0; i < 8; i++) act_ring[i] = 4'h0;
    model_reset();
    vis = nxt;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    chk_en = 1;
    step();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_GoNoGo", 32'(GoNoGo), 32'd0);
    check("reset_err", 32'(err_count), 32'd0);
    check("reset_sig", 32'(signature), 32'd0);

    // All-match sweep over the full address space.
    d0 = done_count;
    begin_session();
    for (int a = 0; a < 256; a++) begin
      if (a == 255) t_last = cyc;
      issue(8'(a), 4'(a) ^ 4'h5, 4'(a) ^ 4'h5, a == 255);
    end
    wait_done();
    check("sweep_done_latency", 32'(cyc - t_last), 32'(LAT + 1));
    check("sweep_GoNoGo", 32'(GoNoGo), 32'd1);
    check("sweep_err", 32'(err_count), 32'd0);
    check("sweep_busy_with_done", 32'(busy), 32'd0);
    step();
    step();
    check("sweep_one_done", 32'(done_count - d0), 32'd1);
    check("sweep_GoNoGo_holds", 32'(GoNoGo), 32'd1);

    // Single fault at 0x3C.
    begin_session();
    for (int a = 8'h30; a <= 8'h4F; a++)
      issue(8'(a), (a == 8'h3C) ? 4'hA : 4'(a), (a == 8'h3C) ? 4'h2 : 4'(a), a == 8'h4F);
    wait_done();
    check("single_GoNoGo", 32'(GoNoGo), 32'd0);
    check("single_err", 32'(err_count), 32'd1);
    check("single_fail_addr", 32'(fail_addr), 32'h3C);
    check("single_fail_exp", 32'(fail_exp), 32'hA);
    check("single_fail_act", 32'(fail_act), 32'h2);
    step();

    // Two faults: first-fail capture stays on 0x10.
    begin_session();
    for (int a = 0; a < 48; a++)
      issue(8'(a), 4'h7, (a == 16 || a == 32) ? 4'h8 : 4'h7, a == 47);
    wait_done();
    check("two_err", 32'(err_count), 32'd2);
    check("two_fail_addr", 32'(fail_addr), 32'h10);
    check("two_fail_act", 32'(fail_act), 32'h8);
    step();

    // Saturation of the error counter.
    begin_session();
    for (int i = 0; i < 300; i++) issue(8'(i), 4'h5, 4'hA, i == 299);
    wait_done();
    check("sat_err", 32'(err_count), 32'd255);
    check("sat_GoNoGo", 32'(GoNoGo), 32'd0);
    check("sat_fail_addr", 32'(fail_addr), 32'h00);
    step();

    // Abort: start with a simultaneous rd_en from IDLE, mismatches, restart, clean run.
    d0 = done_count;
    start = 1;
    issue(8'h01, 4'h1, 4'hE, 1'b1);
    for (int i = 0; i < 5; i++) issue(8'(i), 4'h3, 4'hC, 1'b0);
    begin_session();
    for (int i = 0; i < 4; i++) issue(8'(i + 8'h80), 4'h6, 4'h6, i == 3);
    wait_done();
    check("abort_err", 32'(err_count), 32'd0);
    check("abort_GoNoGo", 32'(GoNoGo), 32'd1);
    step();
    step();
    check("abort_one_done", 32'(done_count - d0), 32'd1);

    // Reset in the middle of a session.
    d0 = done_count;
    begin_session();
    for (int i = 0; i < 3; i++) issue(8'(i), 4'h9, 4'h0, 1'b0);
    issue(8'h03, 4'h9, 4'h9, 1'b1);
    rst = 1;
    model_reset();
    vis = nxt;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_fail_addr", 32'(fail_addr), 32'd0);
    check("rst_fail_act", 32'(fail_act), 32'd0);
    step();
    step();
    rst = 0;
    repeat (6) step();
    check("rst_no_done", 32'(done_count - d0), 32'd0);
    check("rst_GoNoGo", 32'(GoNoGo), 32'd0);

    // MISR: one read of 0x0.
    begin_session();
    issue(8'h00, 4'h0, 4'h0, 1'b1);
    wait_done();
`ifdef BIST_MISR_EN
    check("misr_signature", 32'(signature), 32'hEFDF);
`else
    check("misr_signature", 32'(signature), 32'h0000);
`endif
    check("misr_GoNoGo", 32'(GoNoGo), 32'd1);
    step();
    step();

    chk_en = 0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
